fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 13 +
 rtl/phase_edge_det.sv | 22 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Branch targets are forced word-aligned; sequential flow wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur_pc,
                                                input logic            take_branch,
                                                input logic [XLEN-1:0] target);
        logic [XLEN-1:0] align_mask;
        align_mask = ~(XLEN'(3));
        if (take_branch)
            next_pc = target & align_mask;
        else
            next_pc = cur_pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/phase_edge_det.sv
// Rise/fall detector for a phase level sampled on posedge clk, against a registered history bit.
module phase_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sig_p0 <= 1'b0;
        else
            sig_p0 <= sig;
    end

    assign rise = sig & ~sig_p0;
    assign fall = ~sig & sig_p0;

endmodule

// File: rtl/fetch_unit.sv
// Phase-driven instruction fetch unit: IDLE -> REQ -> HOLD -> execute -> IDLE.
// Optional protocol-error pulse output fetch_err is built only with FETCH_CHECK_EN defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch,
    input  logic            alu_ena,
    input  logic            branch_valid,
    input  logic [XLEN-1:0] branch_target,
    fetch_if.master         imem,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic            exec_strobe
`ifdef FETCH_CHECK_EN
    ,
    output logic            fetch_err
`endif
);

    fetch_state_t state;
    logic         req_q;
    logic         rise;
    logic         fall;

    phase_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (fetch),
        .rise (rise),
        .fall (fall)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // REQ is only held while fetch stays high, so a fall seen in REQ means the window closed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            req_q       <= 1'b0;
            exec_strobe <= 1'b0;
        end else begin
            exec_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        req_q <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (fall) begin
                        req_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (alu_ena) begin
                        exec_strobe <= 1'b1;
                        instr_valid <= 1'b0;
                        pc          <= next_pc(pc, branch_valid, branch_target);
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CHECK_EN
    logic err_cond;

    always_comb begin
        err_cond = 1'b0;
        if ((state == ST_REQ) && !imem.imem_ack && fall)
            err_cond = 1'b1;
        if (alu_ena && (state != ST_HOLD))
            err_cond = 1'b1;
        if (rise && (state != ST_IDLE))
            err_cond = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fetch_err <= 1'b0;
        else
            fetch_err <= err_cond;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-during-request sequence, randomized run vs. model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch;
    logic        alu_ena;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exec_strobe;
`ifdef FETCH_CHECK_EN
    logic        fetch_err;
`endif

    fetch_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch         (fetch),
        .alu_ena       (alu_ena),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .imem          (bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .exec_strobe   (exec_strobe)
`ifdef FETCH_CHECK_EN
        ,
        .fetch_err     (fetch_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        f, a, k, b;
        logic [31:0] rd, tg;
        logic        req, v, s, e;
        logic [31:0] pc, in;
    } vec_t;

    function automatic vec_t mk(input logic f, a, k, b, input logic [31:0] rd, tg,
                                input logic req, v, s, e, input logic [31:0] p, in);
        vec_t r;
        r.f = f; r.a = a; r.k = k; r.b = b; r.rd = rd; r.tg = tg;
        r.req = req; r.v = v; r.s = s; r.e = e; r.pc = p; r.in = in;
        return r;
    endfunction

    // Behavioural reference: outstanding request, held instruction, pc, error pulse.
    logic        m_busy, m_have, m_strobe, m_err, m_prev;
    logic [31:0] m_pc, m_instr;

    task automatic model_reset();
        m_busy = 0; m_have = 0; m_strobe = 0; m_err = 0; m_prev = 0;
        m_pc = 32'h0; m_instr = 32'h0;
    endtask

    task automatic model_step(input logic f, a, k, b, input logic [31:0] rd, tg);
        logic r;
        r = f && !m_prev;
        m_strobe = 0;
        m_err = 0;
        if (m_busy) begin
            if (k) begin
                m_instr = rd; m_have = 1; m_busy = 0;
            end else if (!f) begin
                m_busy = 0; m_err = 1;
            end
            if (a || r) m_err = 1;
        end else if (m_have) begin
            if (a) begin
                m_strobe = 1; m_have = 0;
                m_pc = b ? {tg[31:2], 2'b00} : m_pc + 32'd4;
            end
            if (r) m_err = 1;
        end else begin
            if (r) m_busy = 1;
            if (a) m_err = 1;
        end
        m_prev = f;
    endtask

    task automatic drive(input logic f, a, k, b, input logic [31:0] rd, tg);
        fetch = f; alu_ena = a; bus.imem_ack = k; branch_valid = b;
        bus.imem_rdata = rd; branch_target = tg;
    endtask

    vec_t tbl[25];

    initial begin
        tbl[0]  = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'h0,         32'h0);
        tbl[1]  = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'h0,         32'h0);
        tbl[2]  = mk(1,0,1,0, 32'h13,        32'h0,         0,1,0,0, 32'h0,         32'h13);
        tbl[3]  = mk(0,0,0,0, 32'h0,         32'h0,         0,1,0,0, 32'h0,         32'h13);
        tbl[4]  = mk(0,1,0,0, 32'h0,         32'h0,         0,0,1,0, 32'h4,         32'h13);
        tbl[5]  = mk(0,1,0,0, 32'h0,         32'h0,         0,0,0,1, 32'h4,         32'h13);
        tbl[6]  = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'h4,         32'h13);
        tbl[7]  = mk(1,0,1,0, 32'h0010_0093, 32'h0,         0,1,0,0, 32'h4,         32'h0010_0093);
        tbl[8]  = mk(0,1,0,1, 32'h0,         32'h0000_1003, 0,0,1,0, 32'h0000_1000, 32'h0010_0093);
        tbl[9]  = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'h0000_1000, 32'h0010_0093);
        tbl[10] = mk(0,0,1,0, 32'h0000_ABCD, 32'h0,         0,1,0,0, 32'h0000_1000, 32'h0000_ABCD);
        tbl[11] = mk(0,1,0,1, 32'h0,         32'hFFFF_FFFF, 0,0,1,0, 32'hFFFF_FFFC, 32'h0000_ABCD);
        tbl[12] = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'hFFFF_FFFC, 32'h0000_ABCD);
        tbl[13] = mk(1,0,1,0, 32'h5,         32'h0,         0,1,0,0, 32'hFFFF_FFFC, 32'h5);
        tbl[14] = mk(0,1,0,0, 32'h0,         32'h0,         0,0,1,0, 32'h0,         32'h5);
        tbl[15] = mk(0,0,0,0, 32'h0,         32'h0,         0,0,0,0, 32'h0,         32'h5);
        tbl[16] = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'h0,         32'h5);
        tbl[17] = mk(0,0,0,0, 32'h0,         32'h0,         0,0,0,1, 32'h0,         32'h5);
        tbl[18] = mk(0,0,0,0, 32'h0,         32'h0,         0,0,0,0, 32'h0,         32'h5);
        tbl[19] = mk(1,0,0,0, 32'h0,         32'h0,         1,0,0,0, 32'h0,         32'h5);
        tbl[20] = mk(1,1,0,0, 32'h0,         32'h0,         1,0,0,1, 32'h0,         32'h5);
        tbl[21] = mk(1,0,1,0, 32'h7,         32'h0,         0,1,0,0, 32'h0,         32'h7);
        tbl[22] = mk(0,0,0,0, 32'h0,         32'h0,         0,1,0,0, 32'h0,         32'h7);
        tbl[23] = mk(1,1,0,0, 32'h0,         32'h0,         0,0,1,1, 32'h4,         32'h7);
        tbl[24] = mk(0,0,0,0, 32'h0,         32'h0,         0,0,0,0, 32'h4,         32'h7);

        // Reset state
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_req",    {31'b0, bus.imem_req}, 32'h0);
        chk("rst_pc",     pc, 32'h0);
        chk("rst_valid",  {31'b0, instr_valid}, 32'h0);
        chk("rst_instr",  instr, 32'h0);
        chk("rst_strobe", {31'b0, exec_strobe}, 32'h0);
`ifdef FETCH_CHECK_EN
        chk("rst_err",    {31'b0, fetch_err}, 32'h0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].f, tbl[i].a, tbl[i].k, tbl[i].b, tbl[i].rd, tbl[i].tg);
            @(negedge clk);
            chk($sformatf("vec%0d_req", i),    {31'b0, bus.imem_req}, {31'b0, tbl[i].req});
            chk($sformatf("vec%0d_addr", i),   bus.imem_addr, tbl[i].pc);
            chk($sformatf("vec%0d_valid", i),  {31'b0, instr_valid}, {31'b0, tbl[i].v});
            chk($sformatf("vec%0d_strobe", i), {31'b0, exec_strobe}, {31'b0, tbl[i].s});
            chk($sformatf("vec%0d_pc", i),     pc, tbl[i].pc);
            chk($sformatf("vec%0d_instr", i),  instr, tbl[i].in);
`ifdef FETCH_CHECK_EN
            chk($sformatf("vec%0d_err", i),    {31'b0, fetch_err}, {31'b0, tbl[i].e});
`endif
        end

        // Reset while a request is outstanding; a late ack must be ignored
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rreq_req_up", {31'b0, bus.imem_req}, 32'h1);
        #2;
        rst = 1'b0;
        fetch = 1'b0;
        #1;
        chk("rreq_req_drop", {31'b0, bus.imem_req}, 32'h0);
        chk("rreq_pc",       pc, 32'h0);
        chk("rreq_valid",    {31'b0, instr_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        chk("late_ack_valid", {31'b0, instr_valid}, 32'h0);
        chk("late_ack_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("late_ack_instr", instr, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("late_ack_valid2", {31'b0, instr_valid}, 32'h0);

        // Randomized run against the reference model
        model_reset();
        begin
            logic f, a, k, b;
            logic [31:0] rd, tg;
            f = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 99) < 35) f = ~f;
                a  = ($urandom_range(0, 99) < 25);
                k  = ($urandom_range(0, 99) < 35);
                b  = ($urandom_range(0, 99) < 30);
                rd = $urandom;
                tg = $urandom;
                drive(f, a, k, b, rd, tg);
                model_step(f, a, k, b, rd, tg);
                @(negedge clk);
                chk("rnd_req",    {31'b0, bus.imem_req}, {31'b0, m_busy});
                chk("rnd_addr",   bus.imem_addr, m_pc);
                chk("rnd_valid",  {31'b0, instr_valid}, {31'b0, m_have});
                chk("rnd_strobe", {31'b0, exec_strobe}, {31'b0, m_strobe});
                chk("rnd_pc",     pc, m_pc);
                chk("rnd_instr",  instr, m_instr);
`ifdef FETCH_CHECK_EN
                chk("rnd_err",    {31'b0, fetch_err}, {31'b0, m_err});
`endif
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
